// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// owns the PC and IR, services ecall, halts on illegal or misaligned flow,
// and counts retired instructions.
module multicycle_controller #(
   parameter int unsigned          PC_WIDTH   = 16,
   parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
   parameter bit                   ECALL_HOLD = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   output logic                instr_req,
   input  logic                instr_ready,
   input  logic [31:0]         instr_rdata,
   output logic [31:0]         ir,
   input  logic [31:0]         imm32,
   input  logic                branch,
   input  logic [PC_WIDTH-1:0] jalr_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic [5:0]          alu_control,
   output logic [1:0]          op1_sel,
   output logic                op2_sel,
   output logic                branch_op,
   output logic                mem_req,
   output logic                mem_write,
   input  logic                mem_ready,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                ecall,
   input  logic                ecall_done,
   output logic                halted,
   output logic [1:0]          halt_cause,
   output logic [31:0]         instret,
   output logic [2:0]          state
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ECALL  = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t state_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;

   logic is_load;
   logic is_store;
   logic is_branch;
   logic is_jal;
   logic is_jalr;
   logic is_system;

   logic       dec_legal;
   logic [5:0] dec_alu;
   logic [1:0] dec_op1;
   logic       dec_op2;
   logic       dec_br;

   logic [PC_WIDTH-1:0] pc_plus4;
   logic [PC_WIDTH-1:0] pc_plus_imm;
   logic [PC_WIDTH-1:0] next_pc;
   logic                next_misaligned;
   logic                retire_now;

   // Upper immediate bits and the JALR lsb never feed PC arithmetic.
   logic unused_bits;
   assign unused_bits = ^{imm32[31:PC_WIDTH], jalr_target[0]};

   assign state     = state_q;
   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign funct7_b5 = ir[30];

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_system = (opcode == OP_SYSTEM);

   // Decode the latched IR into legality and ALU steering fields.
   always_comb begin
      dec_legal = 1'b1;
      dec_alu   = 6'b000000;
      dec_op1   = 2'b00;
      dec_op2   = 1'b0;
      dec_br    = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            dec_op2 = (opcode == OP_I);
            case (funct3)
               3'b000: dec_alu = (opcode == OP_R && funct7_b5) ? 6'b001000 : 6'b000000;
               3'b001: dec_alu = 6'b000001;
               3'b010,
               3'b011: dec_alu = (opcode == OP_I) ? 6'b000011 : 6'b000010;
               3'b100: dec_alu = 6'b000100;
               3'b101: dec_alu = funct7_b5 ? 6'b001101 : 6'b000101;
               3'b110: dec_alu = 6'b000110;
               default: dec_alu = 6'b000111;
            endcase
         end
         OP_LOAD, OP_STORE: begin
            dec_op2 = 1'b1;
         end
         OP_BRANCH: begin
            dec_br = 1'b1;
            case (funct3)
               3'b000: dec_alu = 6'b010000;
               3'b001: dec_alu = 6'b010001;
               3'b100: dec_alu = 6'b000010;
               3'b101: dec_alu = 6'b010101;
               3'b110: dec_alu = 6'b010110;
               3'b111: dec_alu = 6'b010111;
               default: dec_alu = 6'b000000;
            endcase
         end
         OP_JALR: begin
            dec_alu = 6'b111111;
            dec_op2 = 1'b1;
         end
         OP_JAL: begin
            dec_alu = 6'b011111;
            dec_op1 = 2'b10;
            dec_op2 = 1'b1;
         end
         OP_AUIPC: begin
            dec_op1 = 2'b01;
            dec_op2 = 1'b1;
         end
         OP_LUI: begin
            dec_op1 = 2'b11;
            dec_op2 = 1'b1;
         end
         OP_SYSTEM: begin
            dec_alu = 6'b000000;
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
   end

   // Next sequential PC for the instruction currently held in IR.
   always_comb begin
      pc_plus4    = pc + PC_WIDTH'(4);
      pc_plus_imm = pc + imm32[PC_WIDTH-1:0];
      next_pc     = pc_plus4;
      if (is_jal || (is_branch && branch)) begin
         next_pc = pc_plus_imm;
      end else if (is_jalr) begin
         next_pc = {jalr_target[PC_WIDTH-1:1], 1'b0};
      end
      next_misaligned = (next_pc[1:0] != 2'b00);
   end

   // Edge on which the current instruction completes and FETCH resumes.
   always_comb begin
      retire_now = 1'b0;
      case (state_q)
         S_EXEC:  retire_now = is_branch;
         S_MEM:   retire_now = is_store && mem_ready;
         S_WB:    retire_now = 1'b1;
         S_ECALL: retire_now = (ECALL_HOLD == 1'b0) || ecall_done;
         default: retire_now = 1'b0;
      endcase
   end

   // Sequencer: state, PC/IR/instret and all registered strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FETCH;
         pc          <= RESET_PC;
         ir          <= NOP_INSTR;
         instret     <= 32'd0;
         halted      <= 1'b0;
         halt_cause  <= 2'b00;
         alu_control <= 6'b000000;
         op1_sel     <= 2'b00;
         op2_sel     <= 1'b0;
         branch_op   <= 1'b0;
         instr_req   <= 1'b0;
         mem_req     <= 1'b0;
         mem_write   <= 1'b0;
         mem_to_reg  <= 1'b0;
         reg_write   <= 1'b0;
         ecall       <= 1'b0;
      end else begin
         // Strobes are pulses unless the target state re-asserts them.
         instr_req  <= 1'b0;
         mem_req    <= 1'b0;
         mem_write  <= 1'b0;
         mem_to_reg <= 1'b0;
         reg_write  <= 1'b0;
         ecall      <= 1'b0;

         if (retire_now) begin
            if (next_misaligned) begin
               state_q    <= S_HALT;
               halted     <= 1'b1;
               halt_cause <= CAUSE_MISALIGN;
            end else begin
               state_q   <= S_FETCH;
               pc        <= next_pc;
               instret   <= instret + 32'd1;
               instr_req <= 1'b1;
            end
         end else begin
            case (state_q)
               S_FETCH: begin
                  if (instr_ready) begin
                     ir      <= instr_rdata;
                     state_q <= S_DECODE;
                  end else begin
                     instr_req <= 1'b1;
                  end
               end
               S_DECODE: begin
                  if (!dec_legal) begin
                     state_q    <= S_HALT;
                     halted     <= 1'b1;
                     halt_cause <= CAUSE_ILLEGAL;
                  end else begin
                     state_q     <= S_EXEC;
                     alu_control <= dec_alu;
                     op1_sel     <= dec_op1;
                     op2_sel     <= dec_op2;
                     branch_op   <= dec_br;
                  end
               end
               S_EXEC: begin
                  if (is_load || is_store) begin
                     state_q   <= S_MEM;
                     mem_req   <= 1'b1;
                     mem_write <= is_store;
                  end else if (is_system) begin
                     state_q <= S_ECALL;
                     ecall   <= 1'b1;
                  end else begin
                     state_q   <= S_WB;
                     reg_write <= 1'b1;
                  end
               end
               S_MEM: begin
                  if (mem_ready) begin
                     state_q    <= S_WB;
                     reg_write  <= 1'b1;
                     mem_to_reg <= 1'b1;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_write <= is_store;
                  end
               end
               S_ECALL: begin
                  ecall <= 1'b1;
               end
               S_HALT: begin
                  state_q <= S_HALT;
               end
               default: begin
                  state_q <= S_HALT;
                  halted  <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
